// File: rtl/ysyx_23060236_btb_upd.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060236_btb_upd
// Description : BTB update controller. It keeps only mispredicted control-flow
//               instructions from the EXU and queues them in a small in-order
//               FIFO. It drains one BTB write per cycle unless fetch holds the
//               BTB, and it counts mispredictions.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060236_btb_upd #(
  parameter int ADDR_LEN = 32,
  parameter int DEPTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic                     exu_is_cf,
  input  logic [ADDR_LEN-1:0]      exu_pc,
  input  logic [ADDR_LEN-1:0]      exu_pred,
  input  logic [ADDR_LEN-1:0]      exu_target,
  input  logic                     flush,
  input  logic                     btb_hold,
  output logic                     btb_wvalid,
  output logic [ADDR_LEN-1:0]      btb_awaddr,
  output logic [ADDR_LEN-1:0]      btb_wdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              perf_mispred
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_CNT_FULL = DEPTH[c_PTR_W:0];
  localparam logic [c_PTR_W:0] c_CNT_ONE  = 1;

  // Payload storage; contents are meaningless until written, so no reset.
  logic [ADDR_LEN-1:0] r_mem_pc  [DEPTH];
  logic [ADDR_LEN-1:0] r_mem_tgt [DEPTH];

  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W:0]    r_count;
  logic [31:0]         r_perf;

  logic w_full;
  logic w_empty;
  logic w_mispred;
  logic w_handshake;
  logic w_push;
  logic w_pop;

  assign w_full      = (r_count == c_CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_mispred   = exu_is_cf & (exu_target != exu_pred);
  // Full-and-held is the only state that can refuse: when not held, the head
  // pops this cycle and frees a slot; during flush the entry is dropped anyway.
  assign exu_ready   = ~w_full | ~btb_hold | flush;
  assign w_handshake = exu_valid & exu_ready;
  assign w_push      = w_handshake & w_mispred & ~flush;
  assign w_pop       = ~w_empty & ~btb_hold & ~flush;

  assign btb_wvalid   = w_pop;
  assign btb_awaddr   = r_mem_pc[r_rd_ptr];
  assign btb_wdata    = r_mem_tgt[r_rd_ptr];
  assign occupancy    = r_count;
  assign perf_mispred = r_perf;

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tail write of {pc, target} for each accepted misprediction.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]  <= exu_pc;
      r_mem_tgt[r_wr_ptr] <= exu_target;
    end
  end

  // Misprediction counter; counts even the ones a flush discards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_handshake && w_mispred) begin
      r_perf <= r_perf + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_btb_upd.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060236_btb_upd
// Description : Self-checking bench. A queue-based model of the update FIFO is
//               compared against the DUT every cycle, with directed scenarios
//               carrying literal expectations and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060236_btb_upd;

  localparam int ADDR_LEN = 32;
  localparam int DEPTH    = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   exu_valid;
  logic                   exu_ready;
  logic                   exu_is_cf;
  logic [ADDR_LEN-1:0]    exu_pc;
  logic [ADDR_LEN-1:0]    exu_pred;
  logic [ADDR_LEN-1:0]    exu_target;
  logic                   flush;
  logic                   btb_hold;
  logic                   btb_wvalid;
  logic [ADDR_LEN-1:0]    btb_awaddr;
  logic [ADDR_LEN-1:0]    btb_wdata;
  logic [$clog2(DEPTH):0] occupancy;
  logic [31:0]            perf_mispred;

  int checks = 0;
  int errors = 0;

  // Reference model: the pending updates as an ordered list plus a counter.
  logic [63:0] m_q[$];
  logic [31:0] m_perf;

  ysyx_23060236_btb_upd #(.ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .exu_valid    (exu_valid),
    .exu_ready    (exu_ready),
    .exu_is_cf    (exu_is_cf),
    .exu_pc       (exu_pc),
    .exu_pred     (exu_pred),
    .exu_target   (exu_target),
    .flush        (flush),
    .btb_hold     (btb_hold),
    .btb_wvalid   (btb_wvalid),
    .btb_awaddr   (btb_awaddr),
    .btb_wdata    (btb_wdata),
    .occupancy    (occupancy),
    .perf_mispred (perf_mispred)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clock) begin
    if (reset) begin
      m_q.delete();
      m_perf = 32'd0;
    end else begin
      bit e_ready, e_wvalid, hs, mis;
      e_ready  = (m_q.size() < DEPTH) || !btb_hold || flush;
      e_wvalid = (m_q.size() > 0) && !btb_hold && !flush;
      chk("m_ready",  exu_ready,  e_ready);
      chk("m_wvalid", btb_wvalid, e_wvalid);
      chk("m_occ",    occupancy,  m_q.size());
      chk("m_perf",   perf_mispred, m_perf);
      if (e_wvalid) begin
        chk("m_awaddr", btb_awaddr, m_q[0][63:32]);
        chk("m_wdata",  btb_wdata,  m_q[0][31:0]);
      end
      hs  = exu_valid && e_ready;
      mis = exu_is_cf && (exu_target != exu_pred);
      if (hs && mis) m_perf = m_perf + 32'd1;
      if (flush) begin
        m_q.delete();
      end else begin
        if (e_wvalid) void'(m_q.pop_front());
        if (hs && mis) m_q.push_back({exu_pc, exu_target});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic cf, input logic [31:0] pc,
                       input logic [31:0] pred, input logic [31:0] tgt);
    exu_valid  = v;
    exu_is_cf  = cf;
    exu_pc     = pc;
    exu_pred   = pred;
    exu_target = tgt;
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    btb_hold = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) cyc();
    reset = 1'b0;
    #2;
    chk("rst_wvalid", btb_wvalid, 1'b0);
    chk("rst_occ",    occupancy,  0);
    chk("rst_ready",  exu_ready,  1'b1);
    chk("rst_perf",   perf_mispred, 32'd0);
    cyc();

    // Single mispredict
    drive(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0014, 32'h8000_0100);
    #2 chk("s_ready", exu_ready, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("s_wvalid", btb_wvalid, 1'b1);
    chk("s_awaddr", btb_awaddr, 32'h8000_0010);
    chk("s_wdata",  btb_wdata,  32'h8000_0100);
    cyc();
    #2;
    chk("s_occ0",  occupancy, 0);
    chk("s_perf1", perf_mispred, 32'd1);

    // Correct prediction, then non-CF with differing next-PC
    drive(1'b1, 1'b1, 32'h8000_0020, 32'h8000_0040, 32'h8000_0040);
    cyc();
    drive(1'b1, 1'b0, 32'h8000_0024, 32'h8000_0028, 32'h8000_0300);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("c_wvalid", btb_wvalid, 1'b0);
    chk("c_perf",   perf_mispred, 32'd1);
    cyc();

    // Hold and fill: A, B accepted, C stalls until release
    btb_hold = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0A00, 32'h0, 32'h0000_0A80);
    cyc();
    drive(1'b1, 1'b1, 32'h0000_0B00, 32'h0, 32'h0000_0B80);
    cyc();
    drive(1'b1, 1'b1, 32'h0000_0C00, 32'h0, 32'h0000_0C80);
    #2;
    chk("h_readyC", exu_ready, 1'b0);
    chk("h_occ2",   occupancy, 2);
    chk("h_wv0",    btb_wvalid, 1'b0);
    cyc();
    btb_hold = 1'b0;
    #2;
    chk("h_readyRel", exu_ready, 1'b1);
    chk("h_wA",       btb_awaddr, 32'h0000_0A00);
    chk("h_dA",       btb_wdata,  32'h0000_0A80);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2 chk("h_wB", btb_awaddr, 32'h0000_0B00);
    cyc();
    #2 chk("h_wC", btb_awaddr, 32'h0000_0C00);
    chk("h_wvC", btb_wvalid, 1'b1);
    cyc();
    #2 chk("h_occ0", occupancy, 0);
    chk("h_perf", perf_mispred, 32'd4);

    // Flush with two pending entries and a concurrent mispredict D
    btb_hold = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_1100, 32'h0, 32'h0000_1180);
    cyc();
    drive(1'b1, 1'b1, 32'h0000_2200, 32'h0, 32'h0000_2280);
    cyc();
    flush = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_D000, 32'h0, 32'h0000_D080);
    #2;
    chk("f_ready",  exu_ready,  1'b1);
    chk("f_wvalid", btb_wvalid, 1'b0);
    cyc();
    flush    = 1'b0;
    btb_hold = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("f_occ0",  occupancy, 0);
    chk("f_wv0",   btb_wvalid, 1'b0);
    chk("f_perf7", perf_mispred, 32'd7);
    cyc();

    // Wrap-around: nine back-to-back mispredicts
    for (int i = 0; i < 10; i++) begin
      if (i < 9) drive(1'b1, 1'b1, 32'h4000_0000 + 32'(i * 4), 32'h0, 32'h5000_0000 + 32'(i));
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #2;
      if (i > 0) begin
        chk("w_wv",   btb_wvalid, 1'b1);
        chk("w_addr", btb_awaddr, 32'h4000_0000 + 32'((i - 1) * 4));
        chk("w_data", btb_wdata,  32'h5000_0000 + 32'(i - 1));
      end
      cyc();
    end
    #2;
    chk("w_occ0", occupancy, 0);
    chk("w_perf", perf_mispred, 32'd16);
    cyc();

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = 32'h100 + 32'($urandom_range(0, 15) * 4);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            32'h8000_0000 + 32'($urandom_range(0, 63) * 4),
            ($urandom_range(0, 1) != 0) ? t : 32'h200 + 32'($urandom_range(0, 15) * 4), t);
      btb_hold = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
